// File: rtl/random_bcd_roller_pkg.sv
// Shared definitions for the random BCD roller: FSM encoding, LFSR taps
// and the constants used by the sample rule and the BCD converter.
package random_bcd_roller_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TICK,
      CONV,
      SHOW
   } state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int          BCD_W     = 4;
   localparam int          MOD_LIMIT = 100;

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter for 0..99 by repeated subtraction of 10;
// one load cycle, one cycle per subtraction, then a registered done pulse.
module bin_to_bcd_seq
   import random_bcd_roller_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [6:0]       bin,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones,
   output logic             done
);

   logic             running;
   logic [6:0]       rem;
   logic [BCD_W-1:0] tens_cnt;

   // start always reloads, so a new request cleanly aborts any stale conversion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         running  <= 1'b0;
         rem      <= '0;
         tens_cnt <= '0;
         tens     <= '0;
         ones     <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            running  <= 1'b1;
            rem      <= bin;
            tens_cnt <= '0;
         end else if (running) begin
            if (rem >= 7'd10) begin
               rem      <= rem - 7'd10;
               tens_cnt <= tens_cnt + BCD_W'(1);
            end else begin
               running <= 1'b0;
               tens    <= tens_cnt;
               ones    <= rem[BCD_W-1:0];
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/random_bcd_roller.sv
// Free-running LFSR plus roll FSM: on a roll press it shows ROLL_TICKS
// pseudo-random 0..99 samples, one per tick, and holds the last as BCD digits.
module random_bcd_roller
   import random_bcd_roller_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          TICK_DIV   = 2500000,
   parameter int          ROLL_TICKS = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             roll,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones,
   output logic             busy,
   output logic             valid
);

   localparam int         TICK_W   = $clog2(TICK_DIV);
   localparam int         SAMPLE_W = $clog2(ROLL_TICKS + 1);
   localparam logic [6:0] MOD_L    = 7'(MOD_LIMIT);

   state_t              state, state_next;
   logic [2:0]          roll_sync;
   logic                roll_p;
   logic [15:0]         lfsr;
   logic [6:0]          raw, val;
   logic [TICK_W-1:0]   tick_cnt;
   logic [SAMPLE_W-1:0] sample_cnt;
   logic                tick_last;
   logic                conv_start, conv_done, cnt_clear, load_out;
   logic [BCD_W-1:0]    conv_tens, conv_ones;

   // Two synchronizer flops plus one history flop for the rising-edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) roll_sync <= '0;
      else     roll_sync <= {roll_sync[1:0], roll};
   end
   assign roll_p = roll_sync[1] & ~roll_sync[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end

   assign raw       = lfsr[6:0];
   assign val       = (raw >= MOD_L) ? (raw - MOD_L) : raw;
   assign tick_last = (tick_cnt == TICK_W'(TICK_DIV - 1));

   bin_to_bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (val),
      .tens  (conv_tens),
      .ones  (conv_ones),
      .done  (conv_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Presses are only honoured from IDLE or SHOW; mid-roll edges fall through
   always_comb begin
      state_next = state;
      conv_start = 1'b0;
      cnt_clear  = 1'b0;
      load_out   = 1'b0;
      case (state)
         IDLE, SHOW: begin
            if (roll_p) begin
               state_next = WAIT_TICK;
               cnt_clear  = 1'b1;
            end
         end
         WAIT_TICK: begin
            if (tick_last) begin
               conv_start = 1'b1;
               state_next = CONV;
            end
         end
         CONV: begin
            if (conv_done) begin
               load_out   = 1'b1;
               state_next = (sample_cnt == SAMPLE_W'(ROLL_TICKS)) ? SHOW : WAIT_TICK;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt   <= '0;
         sample_cnt <= '0;
      end else begin
         if (state != WAIT_TICK || tick_last) tick_cnt <= '0;
         else                                 tick_cnt <= tick_cnt + TICK_W'(1);
         if (cnt_clear)       sample_cnt <= '0;
         else if (conv_start) sample_cnt <= sample_cnt + SAMPLE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tens <= '0;
         ones <= '0;
      end else if (load_out) begin
         tens <= conv_tens;
         ones <= conv_ones;
      end
   end

   assign busy  = (state == WAIT_TICK) || (state == CONV);
   assign valid = (state == SHOW);

endmodule

// File: tb/tb_random_bcd_roller.sv
// Scoreboard bench for random_bcd_roller: expected digit updates are queued
// with their cycle, and a monitor compares them as the DUT presents them.
module tb_random_bcd_roller;

   localparam int TICK_DIV   = 16;
   localparam int ROLL_TICKS = 3;

   typedef struct {
      int         cyc;
      logic [3:0] t;
      logic [3:0] o;
   } exp_t;

   typedef struct {
      int         start;
      logic [3:0] t;
      logic [3:0] o;
   } conv_exp_t;

   logic       clk = 1'b0;
   logic       rst, roll;
   logic [3:0] tens, ones;
   logic       busy, valid;
   logic       cstart, cdone;
   logic [6:0] cbin;
   logic [3:0] ctens, cones;

   int         checks = 0;
   int         passes = 0;
   int         cyc;
   exp_t       sb[$];
   conv_exp_t  cq[$];
   logic [3:0] held_t, held_o;

   always #5 clk = ~clk;

   random_bcd_roller #(
      .LFSR_SEED  (16'hACE1),
      .TICK_DIV   (TICK_DIV),
      .ROLL_TICKS (ROLL_TICKS)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .roll  (roll),
      .tens  (tens),
      .ones  (ones),
      .busy  (busy),
      .valid (valid)
   );

   bin_to_bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (cstart),
      .bin   (cbin),
      .tens  (ctens),
      .ones  (cones),
      .done  (cdone)
   );

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
   endtask

   // Reference LFSR value during cycle n after reset release (taps 16,14,13,11)
   function automatic logic [15:0] modelLfsr(input int n);
      logic [15:0] s;
      s = 16'hACE1;
      for (int i = 0; i < n; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      return s;
   endfunction

   // Queue the expected updates of one roll whose first WAIT_TICK cycle is ws0
   task automatic scheduleRoll(input int ws0, output int second_cyc, output int done_cyc,
                               output logic [3:0] last_t, output logic [3:0] last_o);
      int          ws, t_cyc, raw, v;
      logic [15:0] s;
      exp_t        e;
      ws = ws0;
      second_cyc = 0;
      last_t = 4'd0;
      last_o = 4'd0;
      for (int i = 0; i < ROLL_TICKS; i++) begin
         t_cyc = ws + TICK_DIV - 1;
         s = modelLfsr(t_cyc);
         raw = int'(s & 16'h007F);
         v = raw % 100;
         e.cyc = t_cyc + 3 + v / 10;
         e.t = 4'(v / 10);
         e.o = 4'(v % 10);
         sb.push_back(e);
         if (i == 1) second_cyc = e.cyc;
         last_t = e.t;
         last_o = e.o;
         ws = e.cyc;
      end
      done_cyc = ws;
   endtask

   task automatic waitUntil(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic startRoll(output int r);
      @(posedge clk);
      #1;
      r = cyc;
      roll = 1'b1;
   endtask

   // Converter vector: raw value, mod rule applied here, hand-computed digits
   task automatic applyStimulus(input int raw, input int et, input int eo);
      conv_exp_t c;
      @(posedge clk);
      #1;
      cbin = 7'((raw >= 100) ? raw - 100 : raw);
      cstart = 1'b1;
      c.start = cyc;
      c.t = 4'(et);
      c.o = 4'(eo);
      cq.push_back(c);
      @(posedge clk);
      #1;
      cstart = 1'b0;
      repeat (12) begin
         if (cq.size() == 0) break;
         @(posedge clk);
      end
      #1;
      if (cq.size() != 0) begin
         checks++;
         $display("[TB] FAIL conv_timeout: got no done, expected done within 11 cycles for raw %0d", raw);
         cq.delete();
      end
   endtask

   // Monitor: compares queued updates on their cycle and flags any other change
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            held_t = 4'd0;
            held_o = 4'd0;
         end else begin
            if (sb.size() > 0 && cyc == sb[0].cyc) begin
               checkOutput("update_tens", int'(tens), int'(sb[0].t));
               checkOutput("update_ones", int'(ones), int'(sb[0].o));
               held_t = sb[0].t;
               held_o = sb[0].o;
               void'(sb.pop_front());
            end else if (tens !== held_t || ones !== held_o) begin
               checks++;
               $display("[TB] FAIL unexpected_update: got %0d/%0d, expected held %0d/%0d (cycle %0d)",
                        tens, ones, held_t, held_o, cyc);
               held_t = tens;
               held_o = ones;
            end
            if (cdone) begin
               if (cq.size() == 0) begin
                  checks++;
                  $display("[TB] FAIL conv_spurious_done: got done, expected none (cycle %0d)", cyc);
               end else begin
                  checkOutput("conv_tens", int'(ctens), int'(cq[0].t));
                  checkOutput("conv_ones", int'(cones), int'(cq[0].o));
                  checkOutput("conv_latency_le_11", int'((cyc - cq[0].start) <= 11), 1);
                  void'(cq.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected bench to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         r, up2, done_c;
      logic [3:0] lt, lo, old_t, old_o;
      rst = 1'b1;
      roll = 1'b0;
      cstart = 1'b0;
      cbin = 7'd0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("reset_tens", int'(tens), 0);
      checkOutput("reset_ones", int'(ones), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_valid", int'(valid), 0);
      checkOutput("reset_lfsr_seed", int'(dut.lfsr), 16'hACE1);

      applyStimulus(0, 0, 0);
      applyStimulus(9, 0, 9);
      applyStimulus(10, 1, 0);
      applyStimulus(99, 9, 9);
      applyStimulus(100, 0, 0);
      applyStimulus(127, 2, 7);

      $display("[TB] full roll");
      startRoll(r);
      scheduleRoll(r + 3, up2, done_c, lt, lo);
      waitUntil(r + 2);
      checkOutput("busy_before_rise", int'(busy), 0);
      waitUntil(r + 3);
      checkOutput("busy_rise", int'(busy), 1);
      waitUntil(r + 5);
      roll = 1'b0;
      waitUntil(done_c - 1);
      checkOutput("valid_before_done", int'(valid), 0);
      checkOutput("busy_before_done", int'(busy), 1);
      waitUntil(done_c);
      checkOutput("valid_done", int'(valid), 1);
      checkOutput("busy_done", int'(busy), 0);
      waitUntil(done_c + 200);
      checkOutput("roll1_updates_consumed", sb.size(), 0);
      checkOutput("stable_valid", int'(valid), 1);
      checkOutput("stable_tens", int'(tens), int'(lt));
      checkOutput("stable_ones", int'(ones), int'(lo));
      old_t = lt;
      old_o = lo;

      $display("[TB] re-roll from show with ignored press");
      startRoll(r);
      scheduleRoll(r + 3, up2, done_c, lt, lo);
      waitUntil(r + 2);
      checkOutput("reroll_valid_held", int'(valid), 1);
      waitUntil(r + 3);
      checkOutput("reroll_valid_drop", int'(valid), 0);
      checkOutput("reroll_busy_rise", int'(busy), 1);
      checkOutput("reroll_old_tens", int'(tens), int'(old_t));
      checkOutput("reroll_old_ones", int'(ones), int'(old_o));
      waitUntil(r + 5);
      roll = 1'b0;
      waitUntil(r + 10);
      roll = 1'b1;
      waitUntil(r + 14);
      roll = 1'b0;
      waitUntil(done_c);
      checkOutput("reroll_valid_done", int'(valid), 1);
      checkOutput("reroll_busy_done", int'(busy), 0);
      waitUntil(done_c + 5);
      checkOutput("reroll_updates_consumed", sb.size(), 0);

      $display("[TB] reset mid-roll");
      startRoll(r);
      scheduleRoll(r + 3, up2, done_c, lt, lo);
      waitUntil(r + 5);
      roll = 1'b0;
      waitUntil(up2 + 2);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midreset_tens", int'(tens), 0);
      checkOutput("midreset_ones", int'(ones), 0);
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_valid", int'(valid), 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("postreset_busy", int'(busy), 0);

      startRoll(r);
      scheduleRoll(r + 3, up2, done_c, lt, lo);
      waitUntil(r + 3);
      checkOutput("postreset_busy_rise", int'(busy), 1);
      waitUntil(r + 5);
      roll = 1'b0;
      waitUntil(done_c);
      checkOutput("postreset_valid_done", int'(valid), 1);
      checkOutput("postreset_busy_done", int'(busy), 0);
      waitUntil(done_c + 5);
      checkOutput("postreset_updates_consumed", sb.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
